wb_arb_rr: RTL

Round-robin Wishbone arbiter that lets N bus masters share one single-slave peripheral bus, such as the misc/counter register block. Typical masters are the soft-core CPU and the USB control-endpoint register bridge. It serializes whole transfers and inserts the mandatory idle cycle between them. It also guards the bus with an ack timeout, so an unresponsive slave cannot hang any master.

---
 rtl/wb_arb_rr_if.sv | 30 +++
 rtl/wb_arb_rr.sv | 124 ++++++++++++
 2 files changed

// File: rtl/wb_arb_rr_if.sv
// Bus bundle between N Wishbone masters, the round-robin arbiter and the single shared slave.
// The slave modport is the arbiter's view; the master modport is the surrounding environment.
interface wb_arb_rr_if #(
    parameter int unsigned N  = 2,
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 32
);
    logic [N*AW-1:0] m_addr;
    logic [N*DW-1:0] m_wdata;
    logic [N-1:0]    m_we;
    logic [N-1:0]    m_cyc;
    logic [DW-1:0]   m_rdata;
    logic [N-1:0]    m_ack;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_wdata;
    logic            s_we;
    logic            s_cyc;
    logic [DW-1:0]   s_rdata;
    logic            s_ack;

    modport slave (
        input  m_addr, m_wdata, m_we, m_cyc, s_rdata, s_ack,
        output m_rdata, m_ack, s_addr, s_wdata, s_we, s_cyc
    );

    modport master (
        output m_addr, m_wdata, m_we, m_cyc, s_rdata, s_ack,
        input  m_rdata, m_ack, s_addr, s_wdata, s_we, s_cyc
    );
endinterface

// File: rtl/wb_arb_rr.sv
// Round-robin Wishbone arbiter: one whole transfer at a time, an idle cycle between transfers,
// and an ack timeout that force-completes a stuck transfer and raises a sticky error flag.
module wb_arb_rr #(
    parameter int unsigned N       = 2,
    parameter int unsigned AW      = 8,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    wb_arb_rr_if.slave bus,
    input  logic       err_clr,
    output logic       err_timeout
);
    localparam int unsigned GW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {StIdle, StBusy} state_e;

    state_e        state_q, state_d;
    logic [GW-1:0] g_q, g_d;
    logic [GW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] to_cnt_q, to_cnt_d;
    logic          err_q, err_d;

    logic          found;
    logic [GW-1:0] pick;
    logic [GW-1:0] g_inc;
    logic          cyc_g;
    logic          at_limit;

    // First requesting master scanning ptr, ptr+1, ... modulo N.
    always_comb begin : rr_pick
        int unsigned   idx;
        logic [GW-1:0] idx_g;
        idx   = 0;
        idx_g = '0;
        found = 1'b0;
        pick  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx   = (32'(ptr_q) + k) % N;
            idx_g = GW'(idx);
            if (!found && bus.m_cyc[idx_g]) begin
                found = 1'b1;
                pick  = idx_g;
            end
        end
    end

    assign g_inc    = (32'(g_q) == N - 1) ? '0 : g_q + GW'(1);
    assign cyc_g    = bus.m_cyc[g_q];
    assign at_limit = (to_cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        g_d         = g_q;
        ptr_d       = ptr_q;
        to_cnt_d    = to_cnt_q;
        err_d       = err_q;
        bus.s_cyc   = 1'b0;
        bus.s_addr  = '0;
        bus.s_wdata = '0;
        bus.s_we    = 1'b0;
        bus.m_ack   = '0;
        bus.m_rdata = bus.s_rdata;

        if (err_clr) begin
            err_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (found) begin
                    state_d  = StBusy;
                    g_d      = pick;
                    to_cnt_d = '0;
                end
            end
            StBusy: begin
                bus.s_cyc   = 1'b1;
                bus.s_addr  = bus.m_addr[g_q*AW +: AW];
                bus.s_wdata = bus.m_wdata[g_q*DW +: DW];
                bus.s_we    = bus.m_we[g_q];
                to_cnt_d    = to_cnt_q + CW'(1);
                // A master abandoning its cycle gets no ack and does not advance the pointer.
                if (!cyc_g) begin
                    state_d  = StIdle;
                    to_cnt_d = '0;
                end else if (bus.s_ack) begin
                    bus.m_ack[g_q] = 1'b1;
                    state_d        = StIdle;
                    ptr_d          = g_inc;
                    to_cnt_d       = '0;
                end else if (at_limit) begin
                    bus.m_ack[g_q] = 1'b1;
                    bus.m_rdata    = '1;
                    err_d          = 1'b1;
                    state_d        = StIdle;
                    ptr_d          = g_inc;
                    to_cnt_d       = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            g_q      <= '0;
            ptr_q    <= '0;
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            g_q      <= g_d;
            ptr_q    <= ptr_d;
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
        end
    end

    assign err_timeout = err_q;
endmodule
